// File: rtl/lsu_wb_bridge_if.sv
// Wishbone-classic bus bundle between the load/store bridge (master) and memory (slave).
interface lsu_wb_bridge_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/lsu_wb_bridge.sv
// Load/store unit bridge: one Wishbone-classic transaction per memory op, with
// lane steering, load extension, pipeline stall and misaligned/illegal/bus-error reporting.
module lsu_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_bus_err,
  lsu_wb_bridge_if.master wb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam bit          TIMEOUT_EN_C   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [31:0] TIMEOUT_LAST_C = TIMEOUT_EN_C ? 32'(TIMEOUT_CYCLES - 32'd1) : 32'd0;

  state_t      state_r;
  logic [31:0] cnt_r;
  logic [2:0]  funct3_r;
  logic [1:0]  lane_r;

  logic        bad_req_s;
  logic        timeout_s;
  logic [3:0]  sel_s;
  logic [31:0] dat_s;
  logic [31:0] load_s;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    logic ill;
    case (f3)
      3'b011, 3'b110, 3'b111: ill = 1'b1;
      3'b100, 3'b101:         ill = we;
      default:                ill = 1'b0;
    endcase
    return ill;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = lane[0];
      2'b10:   mis = (lane != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] sel;
    case (f3[1:0])
      2'b00:   sel = 4'b0001 << lane;
      2'b01:   sel = 4'b0011 << lane;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] store_replicate(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend by size.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] dat);
    logic [31:0] sh;
    logic [31:0] r;
    sh = dat >> {lane, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b100:  r = {24'd0, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = dat;
    endcase
    return r;
  endfunction

  // Request decode and bus-phase helpers.
  always_comb begin
    bad_req_s = is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
    sel_s     = lane_sel(req_funct3, req_addr[1:0]);
    dat_s     = store_replicate(req_funct3, req_wdata);
    load_s    = load_extend(funct3_r, lane_r, wb.wb_dat_i);
    if (TIMEOUT_EN_C) begin
      timeout_s = (cnt_r == TIMEOUT_LAST_C);
    end else begin
      timeout_s = 1'b0;
    end
  end

  assign stall = ((state_r == ST_IDLE) && req_valid) || (state_r == ST_BUS);

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      cnt_r           <= 32'd0;
      funct3_r        <= 3'b000;
      lane_r          <= 2'b00;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'd0;
      resp_misaligned <= 1'b0;
      resp_bus_err    <= 1'b0;
      wb.wb_cyc_o     <= 1'b0;
      wb.wb_stb_o     <= 1'b0;
      wb.wb_we_o      <= 1'b0;
      wb.wb_adr_o     <= 32'd0;
      wb.wb_sel_o     <= 4'b0000;
      wb.wb_dat_o     <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          resp_valid      <= 1'b0;
          resp_rdata      <= 32'd0;
          resp_misaligned <= 1'b0;
          resp_bus_err    <= 1'b0;
          cnt_r           <= 32'd0;
          if (req_valid && bad_req_s) begin
            state_r         <= ST_RESP;
            resp_valid      <= 1'b1;
            resp_misaligned <= 1'b1;
          end else if (req_valid) begin
            state_r     <= ST_BUS;
            funct3_r    <= req_funct3;
            lane_r      <= req_addr[1:0];
            wb.wb_cyc_o <= 1'b1;
            wb.wb_stb_o <= 1'b1;
            wb.wb_we_o  <= req_we;
            wb.wb_adr_o <= {req_addr[31:2], 2'b00};
            wb.wb_sel_o <= sel_s;
            wb.wb_dat_o <= dat_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUS: begin
          if (wb.wb_err_i || wb.wb_ack_i || timeout_s) begin
            // err outranks ack; a timeout is reported the same way as err.
            state_r         <= ST_RESP;
            cnt_r           <= 32'd0;
            resp_valid      <= 1'b1;
            resp_misaligned <= 1'b0;
            resp_bus_err    <= wb.wb_err_i || !wb.wb_ack_i;
            resp_rdata      <= (wb.wb_err_i || !wb.wb_ack_i || wb.wb_we_o) ? 32'd0 : load_s;
            wb.wb_cyc_o     <= 1'b0;
            wb.wb_stb_o     <= 1'b0;
            wb.wb_we_o      <= 1'b0;
            wb.wb_sel_o     <= 4'b0000;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        ST_RESP: begin
          state_r         <= ST_IDLE;
          resp_valid      <= 1'b0;
          resp_rdata      <= 32'd0;
          resp_misaligned <= 1'b0;
          resp_bus_err    <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          resp_valid  <= 1'b0;
          wb.wb_cyc_o <= 1'b0;
          wb.wb_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
